// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: pipeline records, data-bus request/response, access sizes.
// Used by mem_access and readdata_align.
package mem_access_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2, MSIZE8 = 2'd3} msize_t;

  typedef struct packed {
    logic   memread;
    logic   memwrite;
    msize_t msize;
    logic   memsext;
  } control_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    control_t   ctl;
    word_t      aluout;
    word_t      srcb;
  } execute_data_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    control_t   ctl;
    word_t      result;
    addr_t      addr;
  } memory_data_t;

  typedef struct packed {
    logic              valid;
    addr_t             addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    word_t             data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} mstate_t;

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input msize_t s);
    case (s)
      MSIZE1:  return 3'b000;
      MSIZE2:  return 3'b001;
      MSIZE4:  return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] size_strobe(input msize_t s);
    case (s)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction
endpackage

// File: rtl/mem_access_readdata_align.sv
// Load-data lane alignment: shifts the addressed bytes down to bit 0, then
// truncates to the access size with sign or zero extension.
module readdata_align
  import mem_access_pkg::*;
(
  input  word_t      i_raw,
  input  logic [2:0] i_addr_lo,
  input  msize_t     i_size,
  input  logic       i_sext,
  output word_t      o_data
);
  word_t w_sh;

  assign w_sh = i_raw >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data = w_sh;
    case (i_size)
      MSIZE1: o_data = i_sext ? {{(DATA_W-8){w_sh[7]}}, w_sh[7:0]}
                              : {{(DATA_W-8){1'b0}}, w_sh[7:0]};
      MSIZE2: o_data = i_sext ? {{(DATA_W-16){w_sh[15]}}, w_sh[15:0]}
                              : {{(DATA_W-16){1'b0}}, w_sh[15:0]};
      MSIZE4: o_data = i_sext ? {{(DATA_W-32){w_sh[31]}}, w_sh[31:0]}
                              : {{(DATA_W-32){1'b0}}, w_sh[31:0]};
      MSIZE8: o_data = w_sh;
    endcase
  end
endmodule

// File: rtl/mem_access.sv
// Memory stage: issues dbus loads/stores, aligns load data, registers dataM.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses trap instead of being force-aligned.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | accepting dataE; a memory op drives dreq combinationally
//  ST_WAIT | request outstanding; dreq replayed from latched copy
module mem_access
  import mem_access_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  execute_data_t dataE,
  input  logic          flush,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output logic          stall_m,
  output logic          misalign,
  output memory_data_t  dataM
);
  mstate_t      r_state;
  dbus_req_t    r_req;
  logic [4:0]   r_dst;
  control_t     r_ctl;
  word_t        r_aluout;
  logic         r_drop;
  logic         r_misalign;
  memory_data_t r_dataM;

  logic       w_memop;
  logic       w_misal;
  logic       w_issue;
  logic [2:0] w_lo_mask;
  addr_t      w_addr;
  dbus_req_t  w_new_req;
  word_t      w_load;
  logic [2:0] w_algn_lo;
  msize_t     w_algn_size;
  logic       w_algn_sext;
  logic       w_unused;

  assign w_memop   = dataE.valid & (dataE.ctl.memread | dataE.ctl.memwrite);
  assign w_lo_mask = size_mask(dataE.ctl.msize);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misal  = w_memop & (|(dataE.aluout[2:0] & w_lo_mask));
  assign w_addr   = dataE.aluout;
  assign misalign = r_misalign;
`else
  assign w_misal  = 1'b0;
  assign w_addr   = {dataE.aluout[ADDR_W-1:3], dataE.aluout[2:0] & ~w_lo_mask};
  assign misalign = 1'b0;
`endif

  // Gated by resetn so a request vanishes the moment reset is asserted.
  assign w_issue = resetn & (r_state == ST_IDLE) & w_memop & ~w_misal & ~flush;
  assign stall_m = resetn & ((r_state == ST_WAIT) | (w_memop & ~w_misal));

  always_comb begin
    w_new_req       = '0;
    w_new_req.valid = 1'b1;
    w_new_req.addr  = w_addr;
    w_new_req.size  = dataE.ctl.msize;
    if (dataE.ctl.memwrite) begin
      w_new_req.strobe = size_strobe(dataE.ctl.msize) << w_addr[2:0];
      w_new_req.data   = dataE.srcb << {w_addr[2:0], 3'b000};
    end
  end

  always_comb begin
    dreq = '0;
    if (r_state == ST_WAIT) dreq = r_req;
    else if (w_issue)       dreq = w_new_req;
  end

  assign w_algn_lo   = (r_state == ST_WAIT) ? r_req.addr[2:0] : w_addr[2:0];
  assign w_algn_size = (r_state == ST_WAIT) ? r_ctl.msize     : dataE.ctl.msize;
  assign w_algn_sext = (r_state == ST_WAIT) ? r_ctl.memsext   : dataE.ctl.memsext;

  readdata_align u_align (
    .i_raw     (dresp.data),
    .i_addr_lo (w_algn_lo),
    .i_size    (w_algn_size),
    .i_sext    (w_algn_sext),
    .o_data    (w_load)
  );

  assign w_unused = ^{dresp.addr_ok, r_misalign};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_dst      <= '0;
      r_ctl      <= '0;
      r_aluout   <= '0;
      r_drop     <= 1'b0;
      r_misalign <= 1'b0;
      r_dataM    <= '0;
    end else begin
      r_misalign <= 1'b0;
      r_dataM    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            if (dresp.data_ok) begin
              r_dataM.valid  <= 1'b1;
              r_dataM.dst    <= dataE.dst;
              r_dataM.ctl    <= dataE.ctl;
              r_dataM.result <= dataE.ctl.memwrite ? dataE.aluout : w_load;
              r_dataM.addr   <= dataE.aluout;
            end else begin
              r_state  <= ST_WAIT;
              r_req    <= w_new_req;
              r_dst    <= dataE.dst;
              r_ctl    <= dataE.ctl;
              r_aluout <= dataE.aluout;
              r_drop   <= 1'b0;
            end
          end else if (dataE.valid && !flush) begin
            // ALU result, or a trapped misaligned access reporting its address
            r_dataM.valid  <= 1'b1;
            r_dataM.dst    <= dataE.dst;
            r_dataM.ctl    <= dataE.ctl;
            r_dataM.result <= dataE.aluout;
            r_dataM.addr   <= dataE.aluout;
            r_misalign     <= w_misal;
          end
        end
        ST_WAIT: begin
          if (dresp.data_ok) begin
            r_state        <= ST_IDLE;
            r_drop         <= 1'b0;
            r_dataM.valid  <= ~(r_drop | flush);
            r_dataM.dst    <= r_dst;
            r_dataM.ctl    <= r_ctl;
            r_dataM.result <= r_ctl.memwrite ? r_aluout : w_load;
            r_dataM.addr   <= r_aluout;
          end else if (flush) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dataM = r_dataM;
endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; honours MEM_MISALIGN_TRAP_EN.
module tb_mem_access;
  import mem_access_pkg::*;

  logic          clk;
  logic          resetn;
  execute_data_t dataE;
  logic          flush;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  logic          stall_m;
  logic          misalign;
  memory_data_t  dataM;

  int nchk = 0;
  int nerr = 0;

  mem_access dut (
    .clk      (clk),
    .resetn   (resetn),
    .dataE    (dataE),
    .flush    (flush),
    .dreq     (dreq),
    .dresp    (dresp),
    .stall_m  (stall_m),
    .misalign (misalign),
    .dataM    (dataM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic execute_data_t mk(input logic rd, input logic wr, input msize_t sz,
                                       input logic sx, input logic [63:0] alu,
                                       input logic [63:0] b, input logic [4:0] d);
    execute_data_t e;
    e             = '0;
    e.valid       = 1'b1;
    e.dst         = d;
    e.ctl.memread = rd;
    e.ctl.memwrite = wr;
    e.ctl.msize   = sz;
    e.ctl.memsext = sx;
    e.aluout      = alu;
    e.srcb        = b;
    return e;
  endfunction

  initial begin
    resetn = 1'b0;
    dataE  = '0;
    flush  = 1'b0;
    dresp  = '0;
    #2;
    chk("rst_dataM_valid", 64'(dataM.valid), 64'd0);
    chk("rst_dreq_valid",  64'(dreq.valid),  64'd0);
    chk("rst_stall",       64'(stall_m),     64'd0);
    chk("rst_misalign",    64'(misalign),    64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick;

    // ALU op
    dataE = mk(1'b0, 1'b0, MSIZE8, 1'b0, 64'h1234, 64'h0, 5'd3);
    #1;
    chk("alu_dreq_valid", 64'(dreq.valid), 64'd0);
    chk("alu_stall",      64'(stall_m),    64'd0);
    tick;
    dataE = '0;
    #1;
    chk("alu_valid",  64'(dataM.valid), 64'd1);
    chk("alu_result", dataM.result,     64'h1234);
    chk("alu_dst",    64'(dataM.dst),   64'd3);
    tick;
    chk("bubble_valid", 64'(dataM.valid), 64'd0);

    // lb 0x1003, sign-extended, data_ok three cycles later
    dataE = mk(1'b1, 1'b0, MSIZE1, 1'b1, 64'h1003, 64'h0, 5'd4);
    #1;
    chk("lb_req_valid", 64'(dreq.valid), 64'd1);
    chk("lb_stall0",    64'(stall_m),    64'd1);
    chk("lb_addr",      dreq.addr,       64'h1003);
    chk("lb_strobe",    64'(dreq.strobe), 64'h00);
    tick;
    chk("lb_stall1", 64'(stall_m), 64'd1);
    tick;
    chk("lb_stall2", 64'(stall_m), 64'd1);
    tick;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h00000000_80000000;
    #1;
    chk("lb_stall3", 64'(stall_m), 64'd1);
    tick;
    dresp = '0;
    dataE = '0;
    #1;
    chk("lb_stall_done", 64'(stall_m),     64'd0);
    chk("lb_valid",      64'(dataM.valid), 64'd1);
    chk("lb_result",     dataM.result,     64'hFFFF_FFFF_FFFF_FF80);

    // sw 0x2004, data_ok in the issue cycle
    dataE = mk(1'b0, 1'b1, MSIZE4, 1'b0, 64'h2004, 64'hDEADBEEF, 5'd0);
    dresp.data_ok = 1'b1;
    #1;
    chk("sw_req_valid", 64'(dreq.valid),  64'd1);
    chk("sw_strobe",    64'(dreq.strobe), 64'hF0);
    chk("sw_data",      dreq.data,        64'hDEADBEEF_00000000);
    tick;
    dresp = '0;
    dataE = '0;
    #1;
    chk("sw_no_wait", 64'(stall_m),     64'd0);
    chk("sw_valid",   64'(dataM.valid), 64'd1);
    chk("sw_result",  dataM.result,     64'h2004);

    // ld in WAIT, flushed on cycle 2, data_ok on cycle 4
    dataE = mk(1'b1, 1'b0, MSIZE8, 1'b0, 64'h4008, 64'h0, 5'd7);
    #1;
    chk("ld_req_valid", 64'(dreq.valid), 64'd1);
    chk("ld_addr0",     dreq.addr,       64'h4008);
    tick;
    chk("ld_addr1", dreq.addr,       64'h4008);
    chk("ld_size1", 64'(dreq.size),  64'(MSIZE8));
    tick;
    flush = 1'b1;
    dataE = mk(1'b0, 1'b0, MSIZE8, 1'b0, 64'h9999, 64'h0, 5'd1);
    #1;
    chk("ld_valid2", 64'(dreq.valid), 64'd1);
    chk("ld_addr2",  dreq.addr,       64'h4008);
    chk("ld_stall2", 64'(stall_m),    64'd1);
    tick;
    flush = 1'b0;
    #1;
    chk("ld_addr3",   dreq.addr,       64'h4008);
    chk("ld_stall3",  64'(stall_m),    64'd1);
    chk("ld_dataM3",  64'(dataM.valid), 64'd0);
    tick;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h1111;
    #1;
    chk("ld_valid4", 64'(dreq.valid), 64'd1);
    chk("ld_stall4", 64'(stall_m),    64'd1);
    tick;
    dresp = '0;
    dataE = '0;
    #1;
    chk("ld_dropped", 64'(dataM.valid), 64'd0);
    chk("ld_stall5",  64'(stall_m),     64'd0);

    // Reset during WAIT
    dataE = mk(1'b1, 1'b0, MSIZE8, 1'b0, 64'h5000, 64'h0, 5'd2);
    tick;
    chk("rw_stall_wait", 64'(stall_m), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rw_dreq_valid", 64'(dreq.valid),  64'd0);
    chk("rw_stall",      64'(stall_m),     64'd0);
    chk("rw_dataM",      64'(dataM.valid), 64'd0);
    dataE = '0;
    #1;
    resetn = 1'b1;
    tick;
    chk("rw_idle_stall", 64'(stall_m), 64'd0);

    // lh 0x3001, zero-extended
    dataE = mk(1'b1, 1'b0, MSIZE2, 1'b0, 64'h3001, 64'h0, 5'd5);
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h12345678_9ABC8001;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lh_trap_noreq", 64'(dreq.valid), 64'd0);
    chk("lh_trap_stall", 64'(stall_m),    64'd0);
    tick;
    dresp = '0;
    dataE = '0;
    #1;
    chk("lh_trap_flag",   64'(misalign),    64'd1);
    chk("lh_trap_valid",  64'(dataM.valid), 64'd1);
    chk("lh_trap_result", dataM.result,     64'h3001);
    tick;
    chk("lh_trap_clear", 64'(misalign), 64'd0);
`else
    chk("lh_req_valid", 64'(dreq.valid),  64'd1);
    chk("lh_addr",      dreq.addr,        64'h3000);
    chk("lh_strobe",    64'(dreq.strobe), 64'h00);
    tick;
    dresp = '0;
    dataE = '0;
    #1;
    chk("lh_valid",    64'(dataM.valid), 64'd1);
    chk("lh_result",   dataM.result,     64'h8001);
    chk("lh_misalign", 64'(misalign),    64'd0);

    // sh 0x3001, forced to halfword alignment
    dataE = mk(1'b0, 1'b1, MSIZE2, 1'b0, 64'h3001, 64'hABCD, 5'd0);
    #1;
    chk("sh_addr",   dreq.addr,        64'h3000);
    chk("sh_strobe", 64'(dreq.strobe), 64'h03);
    chk("sh_data",   dreq.data,        64'hABCD);
    tick;
    dataE = '0;
    #1;
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
